// File: rtl/uart_tx_fifo.sv
// UART transmitter with a power-of-two input FIFO and back-to-back framing.
// Define UART_TX_PARITY_EN to add a parity bit after the data bits.
module uart_tx_fifo #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 434,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4,
   parameter int PARITY_ODD   = 0
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [DATA_WIDTH-1:0]             data_i,
   input  logic                              valid_i,
   output logic                              ready_o,
   output logic                              txd_o,
   output logic                              busy_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int IW = 4;
   localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_DATA = IW'(DATA_WIDTH - 1);
   localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
   localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

   if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_dw
      $error("uart_tx_fifo: DATA_WIDTH must be 5..9");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
   end
   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
      $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
   end

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t                  state_q, state_d;
   logic [BW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [DATA_WIDTH-1:0]   sh_q, sh_d;
   logic                    txd_q, txd_d;
   logic                    busy_q, busy_d;
   logic [CW-1:0]           count_q, count_d;
   logic [PW-1:0]           wr_q, wr_d;
   logic [PW-1:0]           rd_q, rd_d;
   logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]   mem_d [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
   logic                    par_q, par_d;
`endif
   logic                    push;
   logic                    load;
   logic                    bit_end;
   logic [DATA_WIDTH-1:0]   head;

   assign ready_o      = (count_q != FULL);
   assign txd_o        = txd_q;
   assign busy_o       = busy_q;
   assign fifo_count_o = count_q;
   assign push         = valid_i && ready_o;
   assign bit_end      = (cnt_q == BIT_LAST);
   assign head         = mem_q[rd_q];

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      idx_d   = idx_q;
      sh_d    = sh_q;
      txd_d   = txd_q;
      load    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      if (state_q != IDLE && !bit_end) cnt_d = cnt_q + 1'b1;
      unique case (state_q)
         IDLE: load = (count_q != '0);
         START: if (bit_end) begin
            state_d = DATA;
            txd_d   = sh_q[0];
            sh_d    = sh_q >> 1;
            idx_d   = '0;
         end
         DATA: if (bit_end) begin
            if (idx_q == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
               state_d = PARITY;
               txd_d   = par_q;
`else
               state_d = STOP;
               txd_d   = 1'b1;
               idx_d   = '0;
`endif
            end else begin
               txd_d = sh_q[0];
               sh_d  = sh_q >> 1;
               idx_d = idx_q + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_end) begin
            state_d = STOP;
            txd_d   = 1'b1;
            idx_d   = '0;
         end
`endif
         STOP: if (bit_end) begin
            if (idx_q == LAST_STOP) begin
               state_d = IDLE;
               txd_d   = 1'b1;
               load    = (count_q != '0);
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Loading from STOP skips IDLE so queued frames run back-to-back.
      if (load) begin
         state_d = START;
         txd_d   = 1'b0;
         sh_d    = head;
         cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
         par_d   = (^head) ^ (PARITY_ODD != 0);
`endif
      end
      busy_d = (state_d != IDLE);
   end

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (push) begin
         mem_d[wr_q] = data_i;
         wr_d        = wr_q + 1'b1;
      end
      if (load) rd_d = rd_q + 1'b1;
      unique case ({push, load})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         count_q <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         count_q <= count_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three instances (8N1, 7-bit/2-stop,
// and an odd-parity variant), CLKS_PER_BIT=8, FIFO_DEPTH=4.
module tb_uart_tx_fifo;
   localparam int CPB = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [2:0]       vin;
   logic [2:0][8:0]  din;
   logic [2:0]       rdy;
   logic [2:0]       txd;
   logic [2:0]       busy;
   logic [2:0][2:0]  cnt;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1),
                  .FIFO_DEPTH(4), .PARITY_ODD(0)) u0 (
      .clk_i(clk), .rst_i(rst_n), .data_i(din[0][7:0]), .valid_i(vin[0]),
      .ready_o(rdy[0]), .txd_o(txd[0]), .busy_o(busy[0]),
      .fifo_count_o(cnt[0]));

   uart_tx_fifo #(.DATA_WIDTH(7), .CLKS_PER_BIT(CPB), .STOP_BITS(2),
                  .FIFO_DEPTH(4), .PARITY_ODD(0)) u1 (
      .clk_i(clk), .rst_i(rst_n), .data_i(din[1][6:0]), .valid_i(vin[1]),
      .ready_o(rdy[1]), .txd_o(txd[1]), .busy_o(busy[1]),
      .fifo_count_o(cnt[1]));

   uart_tx_fifo #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1),
                  .FIFO_DEPTH(4), .PARITY_ODD(1)) u2 (
      .clk_i(clk), .rst_i(rst_n), .data_i(din[2][7:0]), .valid_i(vin[2]),
      .ready_o(rdy[2]), .txd_o(txd[2]), .busy_o(busy[2]),
      .fifo_count_o(cnt[2]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame_check(input int s, input logic [8:0] w,
                              input int dw, input int stops,
                              input bit odd, input string nm);
      logic [15:0] bits;
      int nb;
      int bad;
      int bbad;
      logic p;
      bits = '0;
      nb = 1;
      for (int i = 0; i < dw; i++) begin
         bits[nb] = w[i];
         nb++;
      end
      p = odd;
      for (int i = 0; i < dw; i++) p = p ^ w[i];
`ifdef UART_TX_PARITY_EN
      bits[nb] = p;
      nb++;
`endif
      for (int i = 0; i < stops; i++) begin
         bits[nb] = 1'b1;
         nb++;
      end
      bbad = 0;
      for (int b = 0; b < nb; b++) begin
         bad = 0;
         for (int c = 0; c < CPB; c++) begin
            if (txd[s] !== bits[b]) bad++;
            if (busy[s] !== 1'b1) bbad++;
            tick();
         end
         checks++;
         if (bad != 0)
            $display("FAIL %s bit %0d: txd wrong in %0d of %0d cycles, required %b",
                     nm, b, bad, CPB, bits[b]);
         else passed++;
      end
      checks++;
      if (bbad != 0)
         $display("FAIL %s busy: low in %0d frame cycles, required high throughout",
                  nm, bbad);
      else passed++;
   endtask

   task automatic push_one(input int s, input logic [8:0] w, input string nm);
      vin[s] = 1'b1;
      din[s] = w;
      tick();
      vin[s] = 1'b0;
      checks++;
      if (cnt[s] !== 3'd1 || txd[s] !== 1'b1 || busy[s] !== 1'b0)
         $display("FAIL %s accept: count=%0d txd=%b busy=%b, required 1 1 0",
                  nm, cnt[s], txd[s], busy[s]);
      else passed++;
      tick();
      checks++;
      if (txd[s] !== 1'b0 || cnt[s] !== 3'd0)
         $display("FAIL %s start latency: txd=%b count=%0d, required 0 0",
                  nm, txd[s], cnt[s]);
      else passed++;
   endtask

   task automatic end_check(input int s, input string nm);
      checks++;
      if (busy[s] !== 1'b0 || txd[s] !== 1'b1)
         $display("FAIL %s end: busy=%b txd=%b, required 0 1", nm, busy[s], txd[s]);
      else passed++;
   endtask

   task automatic test_reset();
      int bad[3];
      vin = 3'b111;
      for (int s = 0; s < 3; s++) din[s] = 9'h05A;
      bad = '{0, 0, 0};
      rst_n = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         for (int s = 0; s < 3; s++)
            if (txd[s] !== 1'b1 || busy[s] !== 1'b0 ||
                rdy[s] !== 1'b1 || cnt[s] !== 3'd0) bad[s]++;
      end
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (bad[s] != 0)
            $display("FAIL reset u%0d: outputs wrong in %0d cycles, required txd=1 busy=0 ready=1 count=0",
                     s, bad[s]);
         else passed++;
      end
      vin = 3'b000;
      rst_n = 1'b1;
      repeat (3) tick();
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (cnt[s] !== 3'd0 || busy[s] !== 1'b0 || txd[s] !== 1'b1)
            $display("FAIL reset leak u%0d: count=%0d busy=%b txd=%b, required 0 0 1",
                     s, cnt[s], busy[s], txd[s]);
         else passed++;
      end
   endtask

   task automatic test_single();
      push_one(0, 9'h0A5, "single");
      frame_check(0, 9'h0A5, 8, 1, 1'b0, "single");
      end_check(0, "single");
   endtask

   task automatic test_back_to_back();
      int k;
      int guard;
      int rbad;
      bit full_seen;
      bit r;
      bit ok;
      k = 1;
      guard = 0;
      rbad = 0;
      full_seen = 1'b0;
      fork
         begin
            while (k <= 6 && guard < 600) begin
               vin[0] = 1'b1;
               din[0] = 9'(k);
               r = rdy[0];
               if (r !== (cnt[0] != 3'd4)) rbad++;
               if (cnt[0] == 3'd4) full_seen = 1'b1;
               tick();
               if (r) k++;
               guard++;
            end
            vin[0] = 1'b0;
         end
         begin
            ok = 1'b0;
            for (int c = 0; c < 20 && !ok; c++) begin
               tick();
               if (txd[0] === 1'b0) ok = 1'b1;
            end
            checks++;
            if (!ok) $display("FAIL burst start: txd never fell within 20 cycles, required fall");
            else begin
               passed++;
               for (int j = 1; j <= 6; j++)
                  frame_check(0, 9'(j), 8, 1, 1'b0, $sformatf("burst w%0d", j));
            end
         end
      join
      checks++;
      if (k != 7) $display("FAIL burst push: %0d words accepted, required 6", k - 1);
      else passed++;
      checks++;
      if (rbad != 0)
         $display("FAIL burst ready: wrong in %0d cycles, required ready=(count!=4)", rbad);
      else passed++;
      checks++;
      if (!full_seen) $display("FAIL burst full: count never 4, required 4");
      else passed++;
      end_check(0, "burst");
      checks++;
      if (cnt[0] !== 3'd0) $display("FAIL burst drain: count=%0d, required 0", cnt[0]);
      else passed++;
   endtask

   task automatic test_reset_midframe();
      int bad;
      vin[0] = 1'b1;
      din[0] = 9'h03C;
      tick();
      din[0] = 9'h011;
      tick();
      din[0] = 9'h022;
      tick();
      vin[0] = 1'b0;
      checks++;
      if (cnt[0] !== 3'd2) $display("FAIL midrst queued: count=%0d, required 2", cnt[0]);
      else passed++;
      repeat (29) tick();
      checks++;
      if (busy[0] !== 1'b1) $display("FAIL midrst busy: busy=%b, required 1", busy[0]);
      else passed++;
      rst_n = 1'b0;
      tick();
      checks++;
      if (txd[0] !== 1'b1 || cnt[0] !== 3'd0 || busy[0] !== 1'b0)
         $display("FAIL midrst flush: txd=%b count=%0d busy=%b, required 1 0 0",
                  txd[0], cnt[0], busy[0]);
      else passed++;
      rst_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 200; c++) begin
         tick();
         if (txd[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0)
         $display("FAIL midrst quiet: activity in %0d cycles, required 0", bad);
      else passed++;
   endtask

   task automatic test_width_stop();
      push_one(1, 9'h055, "width");
      frame_check(1, 9'h055, 7, 2, 1'b0, "width");
      end_check(1, "width");
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      push_one(0, 9'h007, "par even");
      frame_check(0, 9'h007, 8, 1, 1'b0, "par even");
      end_check(0, "par even");
      push_one(2, 9'h007, "par odd");
      frame_check(2, 9'h007, 8, 1, 1'b1, "par odd");
      end_check(2, "par odd");
   endtask
`endif

   initial begin
      vin = '0;
      din = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_reset_midframe();
      test_width_stop();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an input FIFO. It is the next-generation TX path for uart_alu and replaces the fixed 8N1, single-buffer transmitter.
- Accepts words over a valid/ready handshake and queues them.
- Serialises them LSB-first with configurable word width, bit period and stop bits.
- Sends queued words back-to-back with no idle gap.

Parameters:
- DATA_WIDTH, 8, bits per character; legal 5..9.
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal >= 2.
- STOP_BITS, 1, number of stop bits; legal 1 or 2.
- FIFO_DEPTH, 4, queue entries; power of two, >= 2.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
- clk_i  input  1  system clock; all logic on posedge.
- rst_i  input  1  reset, synchronous, active-low.
- data_i  input  DATA_WIDTH  word to transmit.
- valid_i  input  1  data_i valid.
- ready_o  output  1  FIFO can accept a word this cycle.
- txd_o  output  1  serial line, idle high.
- busy_o  output  1  a frame is in progress.
- fifo_count_o  output  $clog2(FIFO_DEPTH+1)  words queued, excluding the word being sent.

Behaviour:
- Reset (rst_i low at posedge), all outputs:
  - txd_o=1, busy_o=0, ready_o=1, fifo_count_o=0.
  - FIFO flushed; FSM to IDLE.
- Reset mid-frame:
  - Line returns high on that edge.
  - The partial frame and all queued words are discarded.
- Handshake:
  - A word is accepted at a posedge when valid_i && ready_o.
  - ready_o = (fifo_count_o != FIFO_DEPTH), derived from registered count only; there is no same-cycle pass-through.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - data_i is not sampled when the handshake is not completed.
- Simultaneous push and pop: the count is unchanged and the data order is preserved.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP. Each state holds txd_o for CLKS_PER_BIT cycles per bit, using a bit-period counter that reloads at each bit boundary.
- IDLE:
  - txd_o=1, busy_o=0.
  - If fifo_count_o>0: pop the head into the shift register, drive txd_o=0, go to START.
  - Latency: a word accepted into an empty FIFO while in IDLE gives txd_o low on the next posedge.
- START: after one bit period, go to DATA.
- DATA:
  - Shift out DATA_WIDTH bits, LSB first.
  - Then go to PARITY (if compiled in) or STOP.
- PARITY: one bit period, then go to STOP.
- STOP:
  - Drive STOP_BITS bit periods of 1.
  - At the end, if the FIFO is non-empty: pop and go directly to START, with no IDLE cycle.
  - Otherwise go to IDLE.
- busy_o = (state != IDLE), registered.
- txd_o is driven from a flop; there is no combinational path from inputs.
- Frame length = (1 + DATA_WIDTH + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 with parity compiled in, else 0.
- Illegal parameters: elaboration-time $error.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - The PARITY state is present and emits one parity bit after the data bits.
  - Parity bit = XOR of the data bits when PARITY_ODD=0 (even parity).
  - Parity bit = inverted XOR when PARITY_ODD=1 (odd parity).
- When undefined:
  - The PARITY state and its logic are absent.
  - DATA goes directly to STOP.
  - PARITY_ODD is ignored.

Test Plan:
- Reset: hold rst_i low 10 cycles with valid_i=1 -> txd_o=1, busy_o=0, ready_o=1, fifo_count_o=0 throughout; nothing is accepted.
- Single word, CLKS_PER_BIT=8, DATA_WIDTH=8, STOP_BITS=1, no parity, push 0xA5:
  - txd_o low 1 cycle after accept for 8 cycles.
  - Then 1,0,1,0,0,1,0,1 at 8 cycles each, then high for 8 cycles.
  - busy_o high for exactly 80 cycles.
- Burst, FIFO_DEPTH=4, valid_i held high with 0x01..0x06:
  - ready_o drops when fifo_count_o=4; no word is lost or duplicated.
  - Six frames in order 0x01..0x06, back-to-back in 480 cycles, no high gap beyond the stop bits.
- Reset mid-frame: rst_i low at cycle 30 of frame 0x3C with 2 words queued -> txd_o=1 after that edge, fifo_count_o=0, busy_o=0; no further frames follow.
- Width and stop bits, DATA_WIDTH=7, STOP_BITS=2, push 0x55 -> 7 data bits 1,0,1,0,1,0,1, two stop bits, frame 80 cycles at CLKS_PER_BIT=8.
- Parity with UART_TX_PARITY_EN defined:
  - Push 0x07 with PARITY_ODD=0 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0.
  - Frame is 88 cycles at CLKS_PER_BIT=8.
